// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2
);
  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [ID_WIDTH-1:0]    msel;
  logic                   bus_busy;
  logic                   timeout;
  logic [ID_WIDTH-1:0]    timeout_id;

  modport master (
    output breq,
    input  bgrant, msel, bus_busy, timeout, timeout_id
  );

  modport slave (
    input  breq,
    output bgrant, msel, bus_busy, timeout, timeout_id
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: grant lands one edge after breq is sampled, tenure capped at MAX_HOLD,
// one TURN plus one IDLE cycle between owners; no preemption while a grant is held.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int MAX_HOLD    = 256,
  parameter int CNT_WIDTH   = 9
) (
  input  logic            clk,
  input  logic            rstn,
  rr_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] bgrant, bgrant_nxt;
  logic [ID_WIDTH-1:0]    msel, msel_nxt;
  logic [ID_WIDTH-1:0]    last_id, last_id_nxt;
  logic [ID_WIDTH-1:0]    timeout_id, timeout_id_nxt;
  logic [ID_WIDTH-1:0]    winner, scan_idx;
  logic [CNT_WIDTH-1:0]   hold_cnt, hold_cnt_nxt;
  logic                   bus_busy, timeout, timeout_nxt;
  logic                   found, limit_hit;

  // Scan starts just after the last owner, so a master that just held the bus ranks last.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = ID_WIDTH'((int'(last_id) + k) % NUM_MASTERS);
      if (!found && bus.breq[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == CNT_WIDTH'(MAX_HOLD - 1));

  always_comb begin
    state_nxt      = state;
    bgrant_nxt     = bgrant;
    msel_nxt       = msel;
    last_id_nxt    = last_id;
    hold_cnt_nxt   = hold_cnt;
    timeout_nxt    = 1'b0;
    timeout_id_nxt = timeout_id;
    case (state)
      IDLE: begin
        if (found) begin
          bgrant_nxt         = '0;
          bgrant_nxt[winner] = 1'b1;
          msel_nxt           = winner;
          last_id_nxt        = winner;
          hold_cnt_nxt       = '0;
          state_nxt          = GRANT;
        end
      end
      GRANT: begin
        // A release on the limit cycle wins over the timeout.
        if (!bus.breq[last_id]) begin
          bgrant_nxt = '0;
          state_nxt  = TURN;
        end else if (limit_hit) begin
          bgrant_nxt     = '0;
          timeout_nxt    = 1'b1;
          timeout_id_nxt = last_id;
          state_nxt      = TURN;
        end else begin
          hold_cnt_nxt = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        bgrant_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bgrant     <= '0;
      msel       <= '0;
      last_id    <= ID_WIDTH'(NUM_MASTERS - 1);
      hold_cnt   <= '0;
      bus_busy   <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      state      <= state_nxt;
      bgrant     <= bgrant_nxt;
      msel       <= msel_nxt;
      last_id    <= last_id_nxt;
      hold_cnt   <= hold_cnt_nxt;
      bus_busy   <= (state_nxt == GRANT);
      timeout    <= timeout_nxt;
      timeout_id <= timeout_id_nxt;
    end
  end

  assign bus.bgrant     = bgrant;
  assign bus.msel       = msel;
  assign bus.bus_busy   = bus_busy;
  assign bus.timeout    = timeout;
  assign bus.timeout_id = timeout_id;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter with MAX_HOLD=8: per-cycle vector tables checked through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_rr_bus_arbiter;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic [1:0] m;
    logic       busy;
    logic       to;
    logic [1:0] tid;
    string      name;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  vec_t tbl[$];
  vec_t sb[$];

  rr_bus_arbiter_if #(.NUM_MASTERS(4), .ID_WIDTH(2)) bus ();

  rr_bus_arbiter #(
    .NUM_MASTERS(4),
    .ID_WIDTH   (2),
    .MAX_HOLD   (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%b msel=%0d busy=%b to=%b tid=%0d, want grant=%b msel=%0d busy=%b to=%b tid=%0d",
                  name, act[9:6], act[5:4], act[3], act[2], act[1:0],
                  exp[9:6], exp[5:4], exp[3], exp[2], exp[1:0]);
  endtask

  function automatic logic [9:0] outs();
    return {bus.bgrant, bus.msel, bus.bus_busy, bus.timeout, bus.timeout_id};
  endfunction

  task automatic add(input string name, input logic [3:0] b, input logic [3:0] g, input logic [1:0] m,
                     input logic busy, input logic to, input logic [1:0] tid);
    vec_t v;
    v.name = name; v.b = b; v.g = g; v.m = m; v.busy = busy; v.to = to; v.tid = tid;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.breq = tbl[i].b;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s[%0d]", e.name, i), outs(), {e.g, e.m, e.busy, e.to, e.tid});
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    bus.breq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 10'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.breq = '0;

    // Single requester
    do_reset();
    for (int i = 0; i < 5; i++) add("single", 4'b0010, 4'b0010, 2'd1, 1, 0, 2'd0);
    add("single_rel", 4'b0000, 4'b0000, 2'd1, 0, 0, 2'd0);
    add("single_idle", 4'b0000, 4'b0000, 2'd1, 0, 0, 2'd0);
    run_table();

    // All four request together; each drops 3 cycles after its grant
    do_reset();
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 3; i++) add("simul_grant", 4'hF, 4'(1 << o), 2'(o), 1, 0, 2'd0);
      add("simul_gap1", 4'hF ^ 4'(1 << o), 4'b0000, 2'(o), 0, 0, 2'd0);
      add("simul_gap2", 4'hF, 4'b0000, 2'(o), 0, 0, 2'd0);
    end
    add("simul_wrap", 4'hF, 4'b0001, 2'd0, 1, 0, 2'd0);
    add("simul_end", 4'h0, 4'b0000, 2'd0, 0, 0, 2'd0);
    add("simul_end", 4'h0, 4'b0000, 2'd0, 0, 0, 2'd0);
    run_table();

    // Fairness: master 2 continuous, master 0 joins a cycle later; both held to timeout
    do_reset();
    add("fair_g2", 4'b0100, 4'b0100, 2'd2, 1, 0, 2'd0);
    for (int i = 0; i < 7; i++) add("fair_g2", 4'b0101, 4'b0100, 2'd2, 1, 0, 2'd0);
    add("fair_to2", 4'b0101, 4'b0000, 2'd2, 0, 1, 2'd2);
    add("fair_gap", 4'b0101, 4'b0000, 2'd2, 0, 0, 2'd2);
    for (int i = 0; i < 8; i++) add("fair_g0", 4'b0101, 4'b0001, 2'd0, 1, 0, 2'd2);
    add("fair_to0", 4'b0101, 4'b0000, 2'd0, 0, 1, 2'd0);
    add("fair_gap", 4'b0101, 4'b0000, 2'd0, 0, 0, 2'd0);
    for (int i = 0; i < 8; i++) add("fair_g2b", 4'b0101, 4'b0100, 2'd2, 1, 0, 2'd0);
    add("fair_to2b", 4'b0101, 4'b0000, 2'd2, 0, 1, 2'd2);
    add("fair_gap", 4'b0101, 4'b0000, 2'd2, 0, 0, 2'd2);
    add("fair_g0b", 4'b0101, 4'b0001, 2'd0, 1, 0, 2'd2);
    add("fair_rel", 4'b0000, 4'b0000, 2'd0, 0, 0, 2'd2);
    add("fair_idle", 4'b0000, 4'b0000, 2'd0, 0, 0, 2'd2);
    run_table();

    // Timeout with a lone requester, then release exactly on the limit cycle
    do_reset();
    for (int i = 0; i < 8; i++) add("to_g2", 4'b0100, 4'b0100, 2'd2, 1, 0, 2'd0);
    add("to_pulse", 4'b0100, 4'b0000, 2'd2, 0, 1, 2'd2);
    add("to_gap", 4'b0100, 4'b0000, 2'd2, 0, 0, 2'd2);
    for (int i = 0; i < 8; i++) add("to_regrant", 4'b0100, 4'b0100, 2'd2, 1, 0, 2'd2);
    add("to_pulse2", 4'b0100, 4'b0000, 2'd2, 0, 1, 2'd2);
    add("to_gap2", 4'b0100, 4'b0000, 2'd2, 0, 0, 2'd2);
    add("to_idle", 4'b0000, 4'b0000, 2'd2, 0, 0, 2'd2);
    for (int i = 0; i < 8; i++) add("lim_g1", 4'b0010, 4'b0010, 2'd1, 1, 0, 2'd2);
    add("lim_rel", 4'b0000, 4'b0000, 2'd1, 0, 0, 2'd2);
    add("lim_idle", 4'b0000, 4'b0000, 2'd1, 0, 0, 2'd2);
    run_table();

    // Asynchronous reset in the middle of a grant
    do_reset();
    add("mid_g3", 4'b1000, 4'b1000, 2'd3, 1, 0, 2'd0);
    add("mid_g3", 4'b1000, 4'b1000, 2'd3, 1, 0, 2'd0);
    run_table();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", outs(), 10'b0);
    @(negedge clk);
    rstn     = 1'b1;
    bus.breq = 4'b1001;
    @(posedge clk);
    #1;
    chk("post_reset_g0", outs(), {4'b0001, 2'd0, 1'b1, 1'b0, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
